// File: rtl/tc_ram_copy_engine.sv
// Block-copy (memmove) engine driving both ports of the dual-port load RAM.
// Moves one word per clock; overlapping regions are copied in the direction that preserves the source.
module tc_ram_copy_engine #(
    parameter int unsigned BIT_WIDTH = 16,
    localparam int unsigned ADDR_W = 16,
    localparam int unsigned LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src,
    input  logic [ADDR_W-1:0]    dst,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_load0,
    output logic                 ram_save,
    output logic [ADDR_W-1:0]    ram_address0,
    output logic [BIT_WIDTH-1:0] ram_in,
    output logic                 ram_load1,
    output logic [ADDR_W-1:0]    ram_address1,
    input  logic [BIT_WIDTH-1:0] ram_out1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_backward;
    logic [ADDR_W-1:0]  w_next_rd_ptr;
    logic [ADDR_W-1:0]  w_next_wr_ptr;
    logic [LEN_W-1:0]   w_next_remaining;
    logic               w_next_backward;
    logic [ADDR_W-1:0]  w_diff;
    logic               w_accept_backward;
    logic               w_degenerate;
    logic               w_copy;

    // Destination lies strictly inside the source window: walk from the top down
    assign w_diff            = ADDR_W'(dst - src);
    assign w_accept_backward = (len != '0) && (w_diff != '0) && (LEN_W'(w_diff) < len);
    assign w_degenerate      = (len == '0) || (src == dst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_remaining <= '0;
            r_backward  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rd_ptr    <= w_next_rd_ptr;
            r_wr_ptr    <= w_next_wr_ptr;
            r_remaining <= w_next_remaining;
            r_backward  <= w_next_backward;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_rd_ptr    = r_rd_ptr;
        w_next_wr_ptr    = r_wr_ptr;
        w_next_remaining = r_remaining;
        w_next_backward  = r_backward;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_degenerate) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state     = S_COPY;
                        w_next_remaining = len;
                        w_next_backward  = w_accept_backward;
                        if (w_accept_backward) begin
                            w_next_rd_ptr = ADDR_W'(src + len - ADDR_W'(1));
                            w_next_wr_ptr = ADDR_W'(dst + len - ADDR_W'(1));
                        end else begin
                            w_next_rd_ptr = src;
                            w_next_wr_ptr = dst;
                        end
                    end
                end
            end
            S_COPY: begin
                w_next_remaining = LEN_W'(r_remaining - LEN_W'(1));
                if (r_backward) begin
                    w_next_rd_ptr = ADDR_W'(r_rd_ptr - ADDR_W'(1));
                    w_next_wr_ptr = ADDR_W'(r_wr_ptr - ADDR_W'(1));
                end else begin
                    w_next_rd_ptr = ADDR_W'(r_rd_ptr + ADDR_W'(1));
                    w_next_wr_ptr = ADDR_W'(r_wr_ptr + ADDR_W'(1));
                end
                if (r_remaining == LEN_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // RAM ports are live only while copying; the data path is a straight read-to-write wire
    assign w_copy       = (r_state == S_COPY);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign ram_load0    = 1'b0;
    assign ram_save     = w_copy;
    assign ram_load1    = w_copy;
    assign ram_address0 = w_copy ? r_wr_ptr : '0;
    assign ram_address1 = w_copy ? r_rd_ptr : '0;
    assign ram_in       = w_copy ? ram_out1 : '0;

endmodule

// File: tb/tb_tc_ram_copy_engine.sv
// Directed bench for tc_ram_copy_engine with a behavioural dual-port RAM (combinational read, negedge write).
module tb_tc_ram_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        ram_load0;
    logic        ram_save;
    logic [15:0] ram_address0;
    logic [15:0] ram_in;
    logic        ram_load1;
    logic [15:0] ram_address1;
    logic [15:0] ram_out1;

    logic [15:0] mem [0:65535];
    logic        pl_we;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    logic [15:0] wr_log [$];
    logic [15:0] rd_log [$];
    int          ld0_cnt;
    int          n_cmp;
    int          n_fail;

    tc_ram_copy_engine #(.BIT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .ram_load0    (ram_load0),
        .ram_save     (ram_save),
        .ram_address0 (ram_address0),
        .ram_in       (ram_in),
        .ram_load1    (ram_load1),
        .ram_address1 (ram_address1),
        .ram_out1     (ram_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_out1 = mem[ram_address1];

    // RAM model plus an access log of every port activity
    always @(negedge clk) begin
        if (ram_save) begin
            mem[ram_address0] <= ram_in;
            wr_log.push_back(ram_address0);
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
        if (ram_load1) rd_log.push_back(ram_address1);
        if (ram_load0) ld0_cnt <= ld0_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(negedge clk);
        #1;
        pl_we = 1'b0;
        tick();
    endtask

    // Issues one request and follows it until busy drops; optionally pulses a second start mid-copy
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input int restart_at, output int busy_n, output int done_n,
                            output int done_at, output int idle_at);
        int c;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        src     = s;
        dst     = d;
        len     = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        c       = 1;
        while (busy && c <= int'(l) + 50) begin
            busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (c == restart_at) begin
                start = 1'b1;
                src   = 16'h0200;
                dst   = 16'h0300;
                len   = 16'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start   = 1'b0;
        idle_at = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if ({ram_load0, ram_save, ram_load1} !== 3'b000) begin n_fail++;
            $display("FAIL reset_strobes: got %b want 000", {ram_load0, ram_save, ram_load1}); end
        n_cmp++; if ({ram_address0, ram_address1, ram_in} !== 48'h0) begin n_fail++;
            $display("FAIL reset_buses: got %h want 0", {ram_address0, ram_address1, ram_in}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        int bn, dn, da, ia, wb, rb;
        logic [15:0] exp [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), exp[i]);
        wb = wr_log.size();
        rb = rd_log.size();
        run_copy(16'h0010, 16'h0040, 16'd4, 0, bn, dn, da, ia);
        n_cmp++; if (bn != 5) begin n_fail++; $display("FAIL fwd_busy_cycles: got %0d want 5", bn); end
        n_cmp++; if (da != 5) begin n_fail++; $display("FAIL fwd_done_cycle: got %0d want 5", da); end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL fwd_done_pulses: got %0d want 1", dn); end
        n_cmp++; if (ia != 6) begin n_fail++; $display("FAIL fwd_idle_cycle: got %0d want 6", ia); end
        n_cmp++; if (wr_log.size() - wb != 4) begin n_fail++;
            $display("FAIL fwd_write_count: got %0d want 4", wr_log.size() - wb); end
        for (int i = 0; i < 4 && wb + i < wr_log.size(); i++) begin
            n_cmp++; if (wr_log[wb+i] !== 16'h0040 + 16'(i)) begin n_fail++;
                $display("FAIL fwd_wr_addr[%0d]: got %h want %h", i, wr_log[wb+i], 16'h0040 + 16'(i)); end
        end
        for (int i = 0; i < 4 && rb + i < rd_log.size(); i++) begin
            n_cmp++; if (rd_log[rb+i] !== 16'h0010 + 16'(i)) begin n_fail++;
                $display("FAIL fwd_rd_addr[%0d]: got %h want %h", i, rd_log[rb+i], 16'h0010 + 16'(i)); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[16'h0040 + 16'(i)] !== exp[i]) begin n_fail++;
                $display("FAIL fwd_data[%0d]: got %h want %h", i, mem[16'h0040 + 16'(i)], exp[i]); end
        end
        n_cmp++; if (ld0_cnt != 0) begin n_fail++; $display("FAIL load0_seen: got %0d want 0", ld0_cnt); end
    endtask

    task automatic test_overlap_up();
        int bn, dn, da, ia, wb;
        logic [15:0] dat [4]  = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        logic [15:0] wexp [4] = '{16'h0025, 16'h0024, 16'h0023, 16'h0022};
        for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), dat[i]);
        wb = wr_log.size();
        run_copy(16'h0020, 16'h0022, 16'd4, 0, bn, dn, da, ia);
        n_cmp++; if (wr_log.size() - wb != 4) begin n_fail++;
            $display("FAIL up_write_count: got %0d want 4", wr_log.size() - wb); end
        for (int i = 0; i < 4 && wb + i < wr_log.size(); i++) begin
            n_cmp++; if (wr_log[wb+i] !== wexp[i]) begin n_fail++;
                $display("FAIL up_wr_addr[%0d]: got %h want %h", i, wr_log[wb+i], wexp[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[16'h0022 + 16'(i)] !== dat[i]) begin n_fail++;
                $display("FAIL up_data[%0d]: got %h want %h", i, mem[16'h0022 + 16'(i)], dat[i]); end
        end
        n_cmp++; if (ia != 6) begin n_fail++; $display("FAIL up_idle_cycle: got %0d want 6", ia); end
    endtask

    task automatic test_overlap_down();
        int bn, dn, da, ia, wb;
        logic [15:0] dat [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        logic [15:0] fin [4] = '{16'h000C, 16'h000D, 16'h000C, 16'h000D};
        for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), dat[i]);
        wb = wr_log.size();
        run_copy(16'h0022, 16'h0020, 16'd2, 0, bn, dn, da, ia);
        n_cmp++; if (wr_log.size() - wb != 2) begin n_fail++;
            $display("FAIL down_write_count: got %0d want 2", wr_log.size() - wb); end
        for (int i = 0; i < 2 && wb + i < wr_log.size(); i++) begin
            n_cmp++; if (wr_log[wb+i] !== 16'h0020 + 16'(i)) begin n_fail++;
                $display("FAIL down_wr_addr[%0d]: got %h want %h", i, wr_log[wb+i], 16'h0020 + 16'(i)); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[16'h0020 + 16'(i)] !== fin[i]) begin n_fail++;
                $display("FAIL down_data[%0d]: got %h want %h", i, mem[16'h0020 + 16'(i)], fin[i]); end
        end
        n_cmp++; if (bn != 3) begin n_fail++; $display("FAIL down_busy_cycles: got %0d want 3", bn); end
    endtask

    task automatic test_degenerate();
        int bn, dn, da, ia, wb, rb;
        logic [15:0] s_v [2] = '{16'h0050, 16'h0030};
        logic [15:0] d_v [2] = '{16'h0060, 16'h0030};
        logic [15:0] l_v [2] = '{16'd0, 16'd8};
        for (int k = 0; k < 2; k++) begin
            wb = wr_log.size();
            rb = rd_log.size();
            run_copy(s_v[k], d_v[k], l_v[k], 0, bn, dn, da, ia);
            n_cmp++; if (wr_log.size() != wb || rd_log.size() != rb) begin n_fail++;
                $display("FAIL degen%0d_ram_access: got %0d writes %0d reads want 0", k,
                         wr_log.size() - wb, rd_log.size() - rb); end
            n_cmp++; if (da != 1) begin n_fail++; $display("FAIL degen%0d_done_cycle: got %0d want 1", k, da); end
            n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL degen%0d_done_pulses: got %0d want 1", k, dn); end
            n_cmp++; if (ia != 2) begin n_fail++; $display("FAIL degen%0d_idle_cycle: got %0d want 2", k, ia); end
        end
    endtask

    task automatic test_wrap_ignored_start();
        int bn, dn, da, ia, wb, rb, extra;
        logic [15:0] dat [3]  = '{16'h1111, 16'h2222, 16'h3333};
        logic [15:0] rexp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 3; i++) preload(rexp[i], dat[i]);
        wb = wr_log.size();
        rb = rd_log.size();
        run_copy(16'hFFFE, 16'h0100, 16'd3, 2, bn, dn, da, ia);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) extra++;
            tick();
        end
        n_cmp++; if (rd_log.size() - rb != 3) begin n_fail++;
            $display("FAIL wrap_read_count: got %0d want 3", rd_log.size() - rb); end
        for (int i = 0; i < 3 && rb + i < rd_log.size(); i++) begin
            n_cmp++; if (rd_log[rb+i] !== rexp[i]) begin n_fail++;
                $display("FAIL wrap_rd_addr[%0d]: got %h want %h", i, rd_log[rb+i], rexp[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mem[16'h0100 + 16'(i)] !== dat[i]) begin n_fail++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, mem[16'h0100 + 16'(i)], dat[i]); end
        end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL wrap_done_pulses: got %0d want 1", dn); end
        n_cmp++; if (bn != 4) begin n_fail++; $display("FAIL wrap_busy_cycles: got %0d want 4", bn); end
        n_cmp++; if (extra != 0 || wr_log.size() - wb != 3) begin n_fail++;
            $display("FAIL wrap_restart_ignored: got %0d busy cycles %0d writes want 0 and 3",
                     extra, wr_log.size() - wb); end
    endtask

    task automatic test_reset_mid_copy();
        int bn, dn, da, ia, wb, busy_seen, done_seen;
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 16'd1 + 16'(i));
        wb    = wr_log.size();
        src   = 16'h0300;
        dst   = 16'h0400;
        len   = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({busy, done, ram_load0, ram_save, ram_load1} !== 5'b0) begin n_fail++;
            $display("FAIL abort_flags: got %b want 00000", {busy, done, ram_load0, ram_save, ram_load1}); end
        n_cmp++; if ({ram_address0, ram_address1, ram_in} !== 48'h0) begin n_fail++;
            $display("FAIL abort_buses: got %h want 0", {ram_address0, ram_address1, ram_in}); end
        n_cmp++; if (wr_log.size() - wb != 4) begin n_fail++;
            $display("FAIL abort_write_count: got %0d want 4", wr_log.size() - wb); end
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_seen++;
            if (done) done_seen++;
            tick();
        end
        n_cmp++; if (busy_seen != 0 || done_seen != 0) begin n_fail++;
            $display("FAIL abort_quiet: got busy %0d done %0d want 0 0", busy_seen, done_seen); end
        run_copy(16'h0010, 16'h0050, 16'd4, 0, bn, dn, da, ia);
        n_cmp++; if (bn != 5 || dn != 1 || da != 5) begin n_fail++;
            $display("FAIL after_abort_timing: got busy %0d done %0d at %0d want 5 1 5", bn, dn, da); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[16'h0050 + 16'(i)] !== 16'd1 + 16'(i)) begin n_fail++;
                $display("FAIL after_abort_data[%0d]: got %h want %h", i, mem[16'h0050 + 16'(i)], 16'd1 + 16'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        int bn1, dn1, da1, ia1, bn2, dn2, da2, ia2;
        run_copy(16'h0010, 16'h0060, 16'd2, 0, bn1, dn1, da1, ia1);
        run_copy(16'h0060, 16'h0070, 16'd2, 0, bn2, dn2, da2, ia2);
        n_cmp++; if (bn1 != 3 || bn2 != 3) begin n_fail++;
            $display("FAIL b2b_busy: got %0d %0d want 3 3", bn1, bn2); end
        n_cmp++; if (mem[16'h0070] !== 16'd1 || mem[16'h0071] !== 16'd2) begin n_fail++;
            $display("FAIL b2b_data: got %h %h want 0001 0002", mem[16'h0070], mem[16'h0071]); end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        ld0_cnt = 0;
        rst     = 1'b1;
        start   = 1'b0;
        src     = '0;
        dst     = '0;
        len     = '0;
        pl_we   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        test_reset();
        test_forward();
        test_overlap_up();
        test_overlap_down();
        test_degenerate();
        test_wrap_ignored_start();
        test_reset_mid_copy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
